// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl : instruction fetch sequencer (IDLE/REQ/HOLD/ERR) with timeout
// Revision   : 1.0
// ============================================================================
module fetch_ctrl #(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic [SIZE-1:0] pc_value,
    output logic            pc_oe_a,
    output logic            pc_post_inc,
    output logic            pc_ld,
    output logic [SIZE-1:0] pc_in,
    output logic [SIZE-1:0] mem_addr,
    output logic            mem_rd,
    input  logic            mem_ready,
    input  logic [SIZE-1:0] mem_data,
    output logic [SIZE-1:0] ir,
    output logic            ir_valid,
    input  logic            ir_ack,
    input  logic            jump_valid,
    input  logic [SIZE-1:0] jump_addr,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_cnt;
    logic [SIZE-1:0] r_ir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Held at zero outside REQ so every REQ entry starts from a cleared count;
    // saturates at TIMEOUT, which is where the ERR transition fires anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      r_cnt <= 8'd0;
        else if (r_state != REQ)                      r_cnt <= 8'd0;
        else if (!mem_ready && (r_cnt != C_TIMEOUT))  r_cnt <= r_cnt + 8'd1;
    end

    // The instruction register is cleared on entry to ERR so no stale word is shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               r_ir <= '0;
        else if ((r_state == REQ) && mem_ready) r_ir <= mem_data;
        else if (w_next == ERR)                 r_ir <= '0;
    end

    assign ir = r_ir;

    always_comb begin
        w_next      = r_state;
        mem_rd      = 1'b0;
        pc_oe_a     = 1'b0;
        mem_addr    = '0;
        pc_post_inc = 1'b0;
        pc_ld       = 1'b0;
        pc_in       = '0;
        ir_valid    = 1'b0;
        err         = 1'b0;
        case (r_state)
            IDLE: begin
                if (fetch_en) w_next = REQ;
            end
            REQ: begin
                mem_rd   = 1'b1;
                pc_oe_a  = 1'b1;
                mem_addr = pc_value;
                if (mem_ready) begin
                    pc_post_inc = 1'b1;
                    w_next      = HOLD;
                end else if (r_cnt == C_TIMEOUT) begin
                    w_next = ERR;
                end
            end
            HOLD: begin
                ir_valid = 1'b1;
                if (ir_ack) begin
                    if (jump_valid) begin
                        pc_ld = 1'b1;
                        pc_in = jump_addr;
                    end
                    w_next = fetch_en ? REQ : IDLE;
                end
            end
            ERR: begin
                err = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 32: width of address, PC and instruction words.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum wait cycles in REQ before error; legal range 1..255.
REQ-003 SHALL have port clk  input  1  clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port fetch_en  input  1  permits new fetches; sampled in IDLE and on ir_ack.
REQ-006 SHALL have port pc_value  input  SIZE  current program-counter value.
REQ-007 SHALL have port pc_oe_a  output  1  enables the PC onto address bus a.
REQ-008 SHALL have port pc_post_inc  output  1  one-cycle PC increment strobe.
REQ-009 SHALL have port pc_ld  output  1  one-cycle PC load strobe.
REQ-010 SHALL have port pc_in  output  SIZE  PC load value.
REQ-011 SHALL have port mem_addr  output  SIZE  read address.
REQ-012 SHALL have port mem_rd  output  1  read request.
REQ-013 SHALL have port mem_ready  input  1  read data valid this cycle.
REQ-014 SHALL have port mem_data  input  SIZE  read data.
REQ-015 SHALL have port ir  output  SIZE  fetched instruction.
REQ-016 SHALL have port ir_valid  output  1  ir holds an unconsumed instruction.
REQ-017 SHALL have port ir_ack  input  1  consumer accepts ir.
REQ-018 SHALL have port jump_valid  input  1  redirect, qualified by ir_ack.
REQ-019 SHALL have port jump_addr  input  SIZE  redirect target.
REQ-020 SHALL have port err  output  1  sticky timeout error.

Function
REQ-021 SHALL implement states IDLE, REQ, HOLD, ERR.
REQ-022 IDLE: fetch_en=1 at an edge -> REQ; otherwise remain in IDLE.
REQ-023 On entry to REQ, SHALL clear the wait counter; mem_addr SHALL equal pc_value throughout REQ.
REQ-024 In REQ, mem_rd=1 and pc_oe_a=1 combinationally; both SHALL be 0 in every other state.
REQ-025 REQ with mem_ready=1: at the edge, ir<=mem_data, pc_post_inc=1 for exactly that cycle, next state HOLD; zero-wait latency is 1 cycle from REQ entry to ir_valid.
REQ-026 REQ with mem_ready=0: wait counter increments; when the counter equals TIMEOUT and mem_ready=0 -> ERR.
REQ-027 mem_ready SHALL be ignored outside REQ.
REQ-028 HOLD: ir_valid=1; ir stable until ir_ack.
REQ-029 HOLD with ir_ack=1: next state REQ if fetch_en=1, else IDLE; ir_valid drops the following cycle.
REQ-030 HOLD with ir_ack=1 and jump_valid=1: pc_ld=1 and pc_in=jump_addr for that cycle; the next REQ uses the loaded PC.
REQ-031 jump_valid without ir_ack SHALL be ignored; pc_ld and pc_post_inc SHALL never be asserted in the same cycle.
REQ-032 ERR: err=1, all other outputs inactive; left only by rst.
REQ-033 Counter width SHALL be 8 bits; it SHALL never wrap within REQ.
REQ-034 pc_in SHALL be 0 whenever pc_ld=0.

Reset
REQ-035 rst=1 SHALL immediately force IDLE; ir=0, ir_valid=0, err=0, counter=0, and all strobes 0, independent of clk.
REQ-036 rst asserted mid-REQ or mid-HOLD SHALL abandon the fetch with no pc_post_inc or pc_ld issued.
REQ-037 After rst falls, the first fetch SHALL start no earlier than the first clk edge with fetch_en=1.

Verification
REQ-038 pc_value=0x100, fetch_en=1, mem_ready=1 with mem_data=0xDEADBEEF -> mem_addr=0x100; one pc_post_inc pulse; ir=0xDEADBEEF with ir_valid=1 one cycle after REQ entry.
REQ-039 mem_ready delayed 3 cycles -> mem_rd held 4 cycles; exactly one pc_post_inc; err=0.
REQ-040 TIMEOUT=4, mem_ready held 0 -> ERR reached 5 cycles after REQ entry; err=1 persists until rst.
REQ-041 In HOLD, ir_ack=1, jump_valid=1, jump_addr=0x2000 -> single pc_ld pulse with pc_in=0x2000; next mem_addr follows pc_value=0x2000.
REQ-042 ir_ack held 0 for 10 cycles -> ir and ir_valid stable; no mem_rd issued.
REQ-043 rst pulsed mid-REQ, asynchronous to clk -> outputs cleared without an edge; no strobes issued; state IDLE.
